clint_timer: RTL
================

CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 The block SHALL have parameter CLINT_BASE, default 64'h0000_0000_0200_0000, the byte base address of the timer window.
REQ-002 The block SHALL have parameter PRESCALE, default 16, the cycles per mtime tick (used only under REQ-030).
REQ-003 Port clk, input, 1, the single clock of the block.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port req_valid, input, 1, request present.
REQ-006 Port req_ready, output, 1, request can be accepted.
REQ-007 Port req_we, input, 1, 1 = write, 0 = read.
REQ-008 Port req_addr, input, 64, byte address, 8-byte aligned.
REQ-009 Port req_wdata, input, 64, write data.
REQ-010 Port req_wmask, input, 8, byte enables; bit i covers wdata[8i+7:8i].
REQ-011 Port resp_valid, output, 1, response present.
REQ-012 Port resp_ready, input, 1, response consumed.
REQ-013 Port resp_rdata, output, 64, read data; 0 for writes.
REQ-014 Port resp_err, output, 1, address not mapped.
REQ-015 Port time_out, output, TimerStruct::TimerPack; _time = mtime, time_int = timer interrupt pending.

Function
REQ-016 Registers SHALL be mtimecmp at CLINT_BASE+0x4000 and mtime at CLINT_BASE+0xBFF8, both 64-bit.
REQ-017 The handshake FSM SHALL have two states: IDLE (req_ready=1, resp_valid=0) and RESP (req_ready=0, resp_valid=1).
REQ-018 In IDLE, req_valid=1 SHALL be accepted; the FSM then moves to RESP on the next edge, giving a 1-cycle response latency.
REQ-019 In RESP, resp_rdata/resp_err SHALL hold stable until resp_ready=1; the FSM then returns to IDLE, with no back-to-back accept in that cycle.
REQ-020 A read SHALL capture the register value at the accept edge, i.e. the pre-increment value.
REQ-021 A write SHALL update the selected register at the accept edge: byte i takes wdata when wmask[i]=1 and keeps its old value otherwise.
REQ-022 An unmapped address SHALL produce resp_err=1 and resp_rdata=0; a write to it SHALL have no effect.
REQ-023 mtime SHALL increment by 1 per tick and wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-024 A write to mtime in the same cycle as a tick SHALL win: the merged write value is stored and that tick is dropped.
REQ-025 time_out.time_int SHALL be combinational: (mtime >= mtimecmp), unsigned 64-bit, from the registered values.
REQ-026 time_out._time SHALL equal the mtime register.

Reset
REQ-027 On rst=1, the block SHALL set mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, FSM=IDLE, resp_rdata=0, resp_err=0 and the prescale counter to 0.
REQ-028 The reset outputs SHALL therefore be req_ready=1, resp_valid=0 and time_int=0.
REQ-029 Reset during RESP SHALL drop the pending response, with no resp_valid in the following cycle.

Configuration
REQ-030 With macro CLINT_TIMER_PRESCALE_EN defined, a counter SHALL run 0..PRESCALE-1; a tick SHALL occur when it equals PRESCALE-1, after which it wraps to 0; a write to mtime SHALL clear the counter.
REQ-031 Without CLINT_TIMER_PRESCALE_EN, a tick SHALL occur every cycle, no counter SHALL be synthesised, and PRESCALE SHALL be ignored.

Structure
REQ-032 The TimerStruct package SHALL hold TimerPack {_time[63:0], time_int}, MTIME_OFFSET=16'hBFF8 and MTIMECMP_OFFSET=16'h4000.
REQ-033 One sub-module, mask_merge (old[63:0], wdata[63:0], wmask[7:0] -> merged[63:0], combinational), SHALL be used for both registers.

Verification
REQ-034 Release reset, idle 10 cycles (macro off) -> _time=10, time_int=0, req_ready=1.
REQ-035 Write mtimecmp=20, mask 8'hFF; wait -> time_int rises in the first cycle with mtime=20 and stays high.
REQ-036 Write mtime=64'hFFFF_FFFF_FFFF_FFFE -> _time reads FFFE, FFFF, then 0, with no stall.
REQ-037 Write mtime with wdata=64'h1122_3344_5566_7788 and wmask=8'h0F while mtime=0 -> mtime=64'h0000_0000_5566_7788 and that cycle's tick is dropped.
REQ-038 Read CLINT_BASE+0x0 with resp_ready held low 3 cycles -> resp_valid=1 and resp_err=1 stable for 4 cycles; req_ready=0 throughout.
REQ-039 Macro on, PRESCALE=4, 40 cycles after reset -> _time=10; assert rst while in RESP -> resp_valid=0 next cycle and mtimecmp=all-ones.

Source files
------------

// File: rtl/clint_timer_pkg.sv
// TimerStruct: shared types and register offsets for the CLINT timer block.
// Holds the exported timer bundle and the byte offsets of the two timer
// registers inside the CLINT window.
package TimerStruct;

  typedef struct packed {
    logic [63:0] _time;
    logic        time_int;
  } TimerPack;

  typedef enum logic [1:0] {
    SEL_NONE     = 2'd0,
    SEL_MTIME    = 2'd1,
    SEL_MTIMECMP = 2'd2
  } reg_sel_e;

  localparam logic [15:0] MTIME_OFFSET    = 16'hBFF8;
  localparam logic [15:0] MTIMECMP_OFFSET = 16'h4000;

  // Absolute byte address of a register given the window base.
  function automatic logic [63:0] reg_addr(input logic [63:0] base,
                                           input logic [15:0] offset);
    return base + {48'h0, offset};
  endfunction

endpackage

// File: rtl/clint_timer_mask_merge.sv
// mask_merge: byte-granular write merge shared by mtime and mtimecmp.
// Each byte of the result comes from wdata when its enable is set and from
// the old register value otherwise.
module mask_merge (
  input  logic [63:0] old,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] merged
);

  // Select each byte independently from new or old data.
  always_comb begin
    merged = old;
    for (int i = 0; i < 8; i++) begin
      if (wmask[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: machine timer (mtime / mtimecmp) behind a one-deep
// request/response port, with a level timer interrupt.
// Optional build macro CLINT_TIMER_PRESCALE_EN: when defined, mtime advances
// once every PRESCALE clocks instead of every clock.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | ready for a request (req_ready=1, resp_valid=0)
//   ST_RESP | response held until resp_ready (req_ready=0, resp_valid=1)
module clint_timer
  import TimerStruct::*;
#(
  parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
  parameter int unsigned PRESCALE   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output TimerPack    time_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [63:0] MTIME_ADDR    = reg_addr(CLINT_BASE, MTIME_OFFSET);
  localparam logic [63:0] MTIMECMP_ADDR = reg_addr(CLINT_BASE, MTIMECMP_OFFSET);

  logic [0:0]  state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  reg_sel_e    sel;
  logic        accept;
  logic        wr_mtime;
  logic        wr_mtimecmp;
  logic        tick;
  logic [63:0] mtime_merged;
  logic [63:0] mtimecmp_merged;

  // Decode the request address; anything other than an exact register hit is unmapped.
  always_comb begin
    sel = SEL_NONE;
    if (req_addr == MTIME_ADDR) begin
      sel = SEL_MTIME;
    end else if (req_addr == MTIMECMP_ADDR) begin
      sel = SEL_MTIMECMP;
    end
  end

  assign accept      = (state_q == ST_IDLE) && req_valid;
  assign wr_mtime    = accept && req_we && (sel == SEL_MTIME);
  assign wr_mtimecmp = accept && req_we && (sel == SEL_MTIMECMP);

  mask_merge u_merge_mtime (
    .old    (mtime_q),
    .wdata  (req_wdata),
    .wmask  (req_wmask),
    .merged (mtime_merged)
  );

  mask_merge u_merge_mtimecmp (
    .old    (mtimecmp_q),
    .wdata  (req_wdata),
    .wmask  (req_wmask),
    .merged (mtimecmp_merged)
  );

`ifdef CLINT_TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(PRESCALE - 1));

  // Prescale count restarts on terminal count and whenever software rewrites mtime.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (wr_mtime || tick) begin
      presc_d = '0;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Timer registers: a software write replaces the tick in the same cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime) begin
      mtime_d = mtime_merged;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    mtimecmp_d = wr_mtimecmp ? mtimecmp_merged : mtimecmp_q;
  end

  // Handshake FSM; read data is the pre-tick value seen at the accept edge.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_RESP;
          err_d   = (sel == SEL_NONE);
          rdata_d = '0;
          if (!req_we) begin
            if (sel == SEL_MTIME) begin
              rdata_d = mtime_q;
            end else if (sel == SEL_MTIMECMP) begin
              rdata_d = mtimecmp_q;
            end
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timer and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Export the time value and the unsigned compare against mtimecmp.
  always_comb begin
    time_out          = '0;
    time_out._time    = mtime_q;
    time_out.time_int = (mtime_q >= mtimecmp_q);
  end

endmodule
